// File: rtl/m3_phase_step_gen_pkg.sv
// Shared motor definitions: FSM encoding, six-step commutation table, gate bit order.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package m3_phase_step_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Smallest round length accepted from the speed calculator.
  localparam int LEN_MIN_DEF = 40;

  // Bit positions inside the 6-bit gate vector {AH,AL,BH,BL,CH,CL}.
  localparam int GATE_AH = 5;
  localparam int GATE_AL = 4;
  localparam int GATE_BH = 3;
  localparam int GATE_BL = 2;
  localparam int GATE_CH = 1;
  localparam int GATE_CL = 0;

  // Commutation patterns, indexed by step 0..5.
  localparam logic [5:0] STEP_TABLE [6] = '{
    6'b100100,
    6'b100001,
    6'b001001,
    6'b011000,
    6'b010010,
    6'b000110
  };

  // True when any phase would have both its high and low switch on.
  function automatic logic shoot_through(input logic [5:0] p);
    return (p[GATE_AH] & p[GATE_AL]) |
           (p[GATE_BH] & p[GATE_BL]) |
           (p[GATE_CH] & p[GATE_CL]);
  endfunction

endpackage

// File: rtl/m3_phase_step_gen_step_table.sv
// Step-table lookup: pattern of the current step, next step in the chosen direction and its pattern.
// Latency: combinational.
// Backpressure: none.
module m3_step_table
  import m3_phase_step_gen_pkg::*;
(
  input  logic [2:0] i_step,
  input  logic       i_dir,
  output logic [5:0] o_pattern,
  output logic [2:0] o_next_step,
  output logic [5:0] o_next_pattern
);

  // Map a step index to its gate pattern; out-of-range steps drive nothing.
  function automatic logic [5:0] lookup(input logic [2:0] s);
    logic [5:0] p;
    case (s)
      3'd0:    p = STEP_TABLE[0];
      3'd1:    p = STEP_TABLE[1];
      3'd2:    p = STEP_TABLE[2];
      3'd3:    p = STEP_TABLE[3];
      3'd4:    p = STEP_TABLE[4];
      3'd5:    p = STEP_TABLE[5];
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  // Direction-aware modulo-6 successor plus both table lookups.
  always_comb begin
    o_next_step = 3'd0;
    if (i_step <= 3'd5) begin
      if (!i_dir) o_next_step = (i_step == 3'd5) ? 3'd0 : i_step + 3'd1;
      else        o_next_step = (i_step == 3'd0) ? 3'd5 : i_step - 3'd1;
    end
    o_pattern      = lookup(i_step);
    o_next_pattern = lookup(o_next_step);
  end

endmodule

// File: rtl/m3_phase_step_gen.sv
// Open-loop six-step commutation generator with dead time and per-round pulse.
// Latency: outputs registered, one clkI after the deciding edge.
// Backpressure: none; workingI/m3forceStopI stop the sequence on the next edge.
module m3_phase_step_gen
  import m3_phase_step_gen_pkg::*;
#(
  parameter int DEAD_CYC = 4,
  parameter int LEN_MIN  = LEN_MIN_DEF
) (
  input  logic        clkI,
  input  logic        nRstI,
  input  logic        workingI,
  input  logic        m3forceStopI,
  input  logic        m3invRotateI,
  input  logic [31:0] roundLenI,
  output logic        nextRound_1O,
  output logic [5:0]  gateO,
  output logic [2:0]  stepIdxO
);

  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_len;
  logic [5:0]  r_prev;
  logic [2:0]  r_dead;
  logic [2:0]  r_step;
  logic [5:0]  r_gate;
  logic        r_next_round;

  logic [5:0]  w_cur_pat;
  logic [2:0]  w_nxt_step;
  logic [5:0]  w_nxt_pat;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_adv;
  logic [31:0] w_len_clamp;

  m3_step_table u_step_table (
    .i_step         (r_step),
    .i_dir          (m3invRotateI),
    .o_pattern      (w_cur_pat),
    .o_next_step    (w_nxt_step),
    .o_next_pattern (w_nxt_pat)
  );

  // Phase accumulator step, advance decision and clamped round length.
  always_comb begin
    w_sum       = {1'b0, r_acc} + 33'd6;
    w_diff      = w_sum - {1'b0, r_len};
    w_adv       = (w_sum >= {1'b0, r_len});
    w_len_clamp = (roundLenI < 32'(LEN_MIN)) ? 32'(LEN_MIN) : roundLenI;
  end

  // Main FSM: IDLE/DEAD/DRIVE with registered gate, step and round pulse.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_state      <= ST_IDLE;
      r_acc        <= 32'd0;
      r_len        <= 32'(LEN_MIN);
      r_prev       <= 6'd0;
      r_dead       <= 3'd0;
      r_step       <= 3'd0;
      r_gate       <= 6'd0;
      r_next_round <= 1'b0;
    end else if (!workingI) begin
      // Disable wins over force-stop and also rewinds the step.
      r_state      <= ST_IDLE;
      r_acc        <= 32'd0;
      r_dead       <= 3'd0;
      r_step       <= 3'd0;
      r_gate       <= 6'd0;
      r_next_round <= 1'b0;
    end else if (m3forceStopI) begin
      r_state      <= ST_IDLE;
      r_acc        <= 32'd0;
      r_dead       <= 3'd0;
      r_gate       <= 6'd0;
      r_next_round <= 1'b0;
    end else begin
      r_next_round <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Start with all gates off for a full dead interval.
          r_state <= ST_DEAD;
          r_len   <= w_len_clamp;
          r_prev  <= 6'd0;
          r_dead  <= 3'(DEAD_CYC);
          r_acc   <= 32'd0;
          r_gate  <= 6'd0;
        end
        ST_DEAD, ST_DRIVE: begin
          if (w_adv) begin
            r_acc   <= w_diff[31:0];
            r_step  <= w_nxt_step;
            r_prev  <= w_cur_pat;
            r_state <= ST_DEAD;
            r_dead  <= 3'(DEAD_CYC);
            r_gate  <= (shoot_through(w_cur_pat & w_nxt_pat)) ? 6'd0 : (w_cur_pat & w_nxt_pat);
            if (w_nxt_step == 3'd0) begin
              // Round boundary: report it and pick up the new speed.
              r_next_round <= 1'b1;
              r_len        <= w_len_clamp;
            end
          end else begin
            r_acc <= w_sum[31:0];
            if (r_state == ST_DEAD) begin
              if (r_dead <= 3'd1) begin
                r_state <= ST_DRIVE;
                r_dead  <= 3'd0;
                r_gate  <= (shoot_through(w_cur_pat)) ? 6'd0 : w_cur_pat;
              end else begin
                r_dead <= r_dead - 3'd1;
                r_gate <= (shoot_through(r_prev & w_cur_pat)) ? 6'd0 : (r_prev & w_cur_pat);
              end
            end else begin
              r_gate <= (shoot_through(w_cur_pat)) ? 6'd0 : w_cur_pat;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gate  <= 6'd0;
        end
      endcase
    end
  end

  assign nextRound_1O = r_next_round;
  assign gateO        = r_gate;
  assign stepIdxO     = r_step;

endmodule

// File: tb/tb_m3_phase_step_gen.sv
// Directed bench for m3_phase_step_gen with hand-computed timing and gate patterns.
// Latency: n/a.
// Backpressure: n/a.
module tb_m3_phase_step_gen;

  logic        clkI = 1'b0;
  logic        nRstI = 1'b0;
  logic        workingI = 1'b0;
  logic        m3forceStopI = 1'b0;
  logic        m3invRotateI = 1'b0;
  logic [31:0] roundLenI = 32'd300;
  logic        nextRound_1O;
  logic [5:0]  gateO;
  logic [2:0]  stepIdxO;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int inv_viol = 0;
  int pulse_cnt = 0;
  logic pulse_d = 1'b0;

  logic [5:0] tbl [6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};

  m3_phase_step_gen #(.DEAD_CYC(4), .LEN_MIN(40)) dut (
    .clkI         (clkI),
    .nRstI        (nRstI),
    .workingI     (workingI),
    .m3forceStopI (m3forceStopI),
    .m3invRotateI (m3invRotateI),
    .roundLenI    (roundLenI),
    .nextRound_1O (nextRound_1O),
    .gateO        (gateO),
    .stepIdxO     (stepIdxO)
  );

  always #5 clkI = ~clkI;

  // Shoot-through and single-cycle pulse watch, every cycle.
  always @(negedge clkI) begin
    if (nRstI) begin
      if ((gateO[5] & gateO[4]) | (gateO[3] & gateO[2]) | (gateO[1] & gateO[0])) begin
        inv_viol++;
        $display("FAIL shoot_through gate=%b at %0t", gateO, $time);
      end
      if (nextRound_1O && pulse_d) begin
        inv_viol++;
        $display("FAIL pulse_width pulse high two cycles at %0t", $time);
      end
      if (nextRound_1O) pulse_cnt++;
      pulse_d = nextRound_1O;
    end else begin
      pulse_d = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clkI);
    #1;
  endtask

  // Tick until the step changes; n counts edges, starting from 'start'.
  task automatic wait_adv(input int start, output int n);
    logic [2:0] s0;
    s0 = stepIdxO;
    n = start;
    while (stepIdxO === s0 && n < 1000) begin
      tick();
      n++;
    end
    if (stepIdxO === s0) begin
      chk_cnt++;
      $display("FAIL wait_adv no step change within %0d cycles (step=%0d)", n, stepIdxO);
      n = -1;
    end
  endtask

  // Clear the block, then enable it; returns right after the IDLE->DEAD edge.
  task automatic restart(input logic [31:0] len);
    workingI = 1'b0;
    m3forceStopI = 1'b0;
    m3invRotateI = 1'b0;
    tick();
    roundLenI = len;
    workingI = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    nRstI = 1'b0;
    repeat (3) tick();
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL reset_gate got %b want %b", gateO, 6'd0); else pass_cnt++;
    chk_cnt++; if (stepIdxO !== 3'd0) $display("FAIL reset_step got %0d want 0", stepIdxO); else pass_cnt++;
    chk_cnt++; if (nextRound_1O !== 1'b0) $display("FAIL reset_pulse got %b want 0", nextRound_1O); else pass_cnt++;
    nRstI = 1'b1;
    tick();
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL idle_gate got %b want 0", gateO); else pass_cnt++;
  endtask

  // roundLenI=10 clamps to 40: first advance at 7 edges (42>=40); also dead window 0->1.
  task automatic test_clamp_dead();
    int n;
    restart(32'd10);
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL entry_gate got %b want 0", gateO); else pass_cnt++;
    repeat (3) tick();
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL entry_dead_gate got %b want 0", gateO); else pass_cnt++;
    tick();
    chk_cnt++; if (gateO !== 6'b100100) $display("FAIL first_drive got %b want 100100", gateO); else pass_cnt++;
    wait_adv(4, n);
    chk_cnt++; if (n !== 7) $display("FAIL clamp_len first advance after %0d want 7", n); else pass_cnt++;
    chk_cnt++; if (stepIdxO !== 3'd1) $display("FAIL clamp_step got %0d want 1", stepIdxO); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (gateO !== 6'b100000) $display("FAIL dead_0to1 cyc %0d got %b want 100000", i, gateO); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (gateO !== 6'b100001) $display("FAIL drive_1 got %b want 100001", gateO); else pass_cnt++;
  endtask

  // lenL=300: advance every 50 cycles through all six steps with correct patterns and pulse.
  task automatic test_round_300();
    int n;
    int prev;
    int start;
    logic [2:0] exp_s;
    restart(32'd300);
    prev = 0;
    start = 0;
    for (int i = 0; i < 6; i++) begin
      wait_adv(start, n);
      exp_s = 3'((prev + 1) % 6);
      chk_cnt++; if (n !== 50) $display("FAIL r300_spacing adv %0d got %0d want 50", i, n); else pass_cnt++;
      chk_cnt++; if (stepIdxO !== exp_s) $display("FAIL r300_step got %0d want %0d", stepIdxO, exp_s); else pass_cnt++;
      chk_cnt++; if (gateO !== (tbl[prev] & tbl[exp_s])) $display("FAIL r300_dead got %b want %b", gateO, tbl[prev] & tbl[exp_s]); else pass_cnt++;
      chk_cnt++; if (nextRound_1O !== (exp_s == 3'd0)) $display("FAIL r300_pulse step %0d got %b want %b", exp_s, nextRound_1O, exp_s == 3'd0); else pass_cnt++;
      repeat (3) tick();
      chk_cnt++; if (gateO !== (tbl[prev] & tbl[exp_s])) $display("FAIL r300_dead_end got %b want %b", gateO, tbl[prev] & tbl[exp_s]); else pass_cnt++;
      tick();
      chk_cnt++; if (gateO !== tbl[exp_s]) $display("FAIL r300_drive got %b want %b", gateO, tbl[exp_s]); else pass_cnt++;
      prev = int'(exp_s);
      start = 4;
    end
  endtask

  // roundLenI=100: first advance at 17; 36 advances (6 rounds) land exactly at cycle 600.
  task automatic test_len_100();
    int n;
    int total;
    int p0;
    restart(32'd100);
    p0 = pulse_cnt;
    wait_adv(0, n);
    chk_cnt++; if (n !== 17) $display("FAIL l100_first got %0d want 17", n); else pass_cnt++;
    total = n;
    for (int i = 0; i < 35; i++) begin
      wait_adv(0, n);
      total += n;
    end
    tick();
    chk_cnt++; if (total !== 600) $display("FAIL l100_total got %0d want 600", total); else pass_cnt++;
    chk_cnt++; if (pulse_cnt - p0 !== 6) $display("FAIL l100_pulses got %0d want 6", pulse_cnt - p0); else pass_cnt++;
  endtask

  // Direction flip mid-round at step 2: acc keeps running, goes 1, 0 (pulse), 5.
  task automatic test_reverse();
    int n;
    restart(32'd300);
    wait_adv(0, n);
    wait_adv(0, n);
    chk_cnt++; if (stepIdxO !== 3'd2) $display("FAIL rev_pre got %0d want 2", stepIdxO); else pass_cnt++;
    repeat (10) tick();
    m3invRotateI = 1'b1;
    wait_adv(10, n);
    chk_cnt++; if (n !== 50) $display("FAIL rev_spacing got %0d want 50", n); else pass_cnt++;
    chk_cnt++; if (stepIdxO !== 3'd1) $display("FAIL rev_step1 got %0d want 1", stepIdxO); else pass_cnt++;
    wait_adv(0, n);
    chk_cnt++; if (stepIdxO !== 3'd0) $display("FAIL rev_step0 got %0d want 0", stepIdxO); else pass_cnt++;
    chk_cnt++; if (nextRound_1O !== 1'b1) $display("FAIL rev_pulse got %b want 1", nextRound_1O); else pass_cnt++;
    wait_adv(0, n);
    chk_cnt++; if (stepIdxO !== 3'd5) $display("FAIL rev_step5 got %0d want 5", stepIdxO); else pass_cnt++;
    chk_cnt++; if (n !== 50) $display("FAIL rev_spacing5 got %0d want 50", n); else pass_cnt++;
    m3invRotateI = 1'b0;
  endtask

  // roundLenI 300->150 at step 3: rest of round stays 50/step, next round 25/step.
  task automatic test_len_change();
    int n;
    restart(32'd300);
    repeat (3) wait_adv(0, n);
    chk_cnt++; if (stepIdxO !== 3'd3) $display("FAIL lc_pre got %0d want 3", stepIdxO); else pass_cnt++;
    roundLenI = 32'd150;
    for (int i = 0; i < 3; i++) begin
      wait_adv(0, n);
      chk_cnt++; if (n !== 50) $display("FAIL lc_old_round adv %0d got %0d want 50", i, n); else pass_cnt++;
    end
    chk_cnt++; if (stepIdxO !== 3'd0) $display("FAIL lc_land got %0d want 0", stepIdxO); else pass_cnt++;
    wait_adv(0, n);
    chk_cnt++; if (n !== 25) $display("FAIL lc_new_round got %0d want 25", n); else pass_cnt++;
    chk_cnt++; if (stepIdxO !== 3'd1) $display("FAIL lc_step got %0d want 1", stepIdxO); else pass_cnt++;
  endtask

  // Force-stop holds step and clears acc; disable rewinds step and beats force-stop.
  task automatic test_stop();
    int n;
    restart(32'd300);
    wait_adv(0, n);
    repeat (10) tick();
    chk_cnt++; if (gateO !== 6'b100001) $display("FAIL stop_pre got %b want 100001", gateO); else pass_cnt++;
    m3forceStopI = 1'b1;
    tick();
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL fstop_gate got %b want 0", gateO); else pass_cnt++;
    chk_cnt++; if (stepIdxO !== 3'd1) $display("FAIL fstop_step got %0d want 1", stepIdxO); else pass_cnt++;
    repeat (3) tick();
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL fstop_hold got %b want 0", gateO); else pass_cnt++;
    m3forceStopI = 1'b0;
    tick();
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL restart_gate got %b want 0", gateO); else pass_cnt++;
    wait_adv(0, n);
    chk_cnt++; if (n !== 50) $display("FAIL restart_acc got %0d want 50", n); else pass_cnt++;
    chk_cnt++; if (stepIdxO !== 3'd2) $display("FAIL restart_step got %0d want 2", stepIdxO); else pass_cnt++;
    m3forceStopI = 1'b1;
    workingI = 1'b0;
    tick();
    chk_cnt++; if (stepIdxO !== 3'd0) $display("FAIL disable_step got %0d want 0", stepIdxO); else pass_cnt++;
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL disable_gate got %b want 0", gateO); else pass_cnt++;
    m3forceStopI = 1'b0;
  endtask

  // Reset asserted mid-cycle must clear outputs without waiting for a clock edge.
  task automatic test_async_reset();
    int n;
    restart(32'd300);
    wait_adv(0, n);
    #2;
    nRstI = 1'b0;
    #1;
    chk_cnt++; if (stepIdxO !== 3'd0) $display("FAIL async_step got %0d want 0", stepIdxO); else pass_cnt++;
    chk_cnt++; if (gateO !== 6'd0) $display("FAIL async_gate got %b want 0", gateO); else pass_cnt++;
    tick();
    nRstI = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_clamp_dead();
    test_round_300();
    test_len_100();
    test_reverse();
    test_len_change();
    test_stop();
    test_async_reset();
    chk_cnt++; if (inv_viol !== 0) $display("FAIL invariants got %0d violations want 0", inv_viol); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
